// File: rtl/alu_mseq.sv
// Handshaked ALU: single-cycle RV32I-style base ops plus iterative
// shift-add multiply and restoring divide for the M extension.
module alu_mseq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_in_A,
  input  logic [WIDTH-1:0] alu_in_B,
  input  logic [2:0]       func,
  input  logic             control,
  input  logic             m_ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] CNT_MAX  = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [SHW:0]         r_cnt;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_out;
  logic                 r_div;
  logic                 r_hi;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_bzero;

  logic                 w_accept;
  logic                 w_last;
  logic [SHW-1:0]       w_shamt;
  logic signed [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0]     w_base;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_mfull;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_qfix;
  logic [WIDTH-1:0]     w_rfix;
  logic [WIDTH-1:0]     w_calc_res;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_LAST);

  // Single-cycle base operations, computed straight from the inputs
  assign w_shamt = alu_in_B[SHW-1:0];
  assign w_sra   = $signed(alu_in_A) >>> w_shamt;

  always_comb begin
    w_base = '0;
    unique case (func)
      3'b000: w_base = control ? alu_in_A : alu_in_A + alu_in_B;
      3'b001: w_base = alu_in_A << w_shamt;
      3'b010: w_base = {{(WIDTH-1){1'b0}}, ($signed(alu_in_A) < $signed(alu_in_B))};
      3'b011: w_base = {{(WIDTH-1){1'b0}}, (alu_in_A < alu_in_B)};
      3'b100: w_base = alu_in_A ^ alu_in_B;
      3'b101: w_base = control ? $unsigned(w_sra) : alu_in_A >> w_shamt;
      3'b110: w_base = alu_in_A | alu_in_B;
      default: w_base = alu_in_A & alu_in_B;
    endcase
  end

  // Operand signedness per M op; MUL keeps the low half, so it runs unsigned
  always_comb begin
    if (func[2]) begin
      w_sa = alu_in_A[WIDTH-1] & ~func[0];
      w_sb = alu_in_B[WIDTH-1] & ~func[0];
    end else begin
      w_sa = alu_in_A[WIDTH-1] & ((func[1:0] == 2'b01) || (func[1:0] == 2'b10));
      w_sb = alu_in_B[WIDTH-1] & (func[1:0] == 2'b01);
    end
    w_mag_a = w_sa ? -alu_in_A : alu_in_A;
    w_mag_b = w_sb ? -alu_in_B : alu_in_B;
  end

  // {r_acc, r_lo} is the product register for multiply and the
  // remainder/quotient pair for divide; r_opb is multiplicand or divisor.
  always_comb begin
    w_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_prod  = {w_sum, r_lo[WIDTH-1:1]};
    w_trial = {r_acc, r_lo[WIDTH-1]};
    w_diff  = w_trial - {1'b0, r_opb};
    w_qbit  = ~w_diff[WIDTH];
    w_rem   = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quo   = {r_lo[WIDTH-2:0], w_qbit};
    w_mfull = r_neg_q ? -w_prod : w_prod;
    w_qfix  = r_bzero ? '1 : (r_neg_q ? -w_quo : w_quo);
    w_rfix  = r_neg_r ? -w_rem : w_rem;
    if (r_div) w_calc_res = r_hi ? w_rfix : w_qfix;
    else       w_calc_res = r_hi ? w_mfull[2*WIDTH-1:WIDTH] : w_mfull[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = m_ext ? S_CALC : S_DONE;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) & rst_n;
    busy      = (r_state == S_CALC);
    out_valid = (r_state == S_DONE);
  end

  assign alu_out = r_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_out   <= '0;
      r_div   <= 1'b0;
      r_hi    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (m_ext) begin
        r_div   <= func[2];
        r_hi    <= func[2] ? func[1] : (func[1:0] != 2'b00);
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_bzero <= (alu_in_B == '0);
        r_acc   <= '0;
        r_opb   <= func[2] ? w_mag_b : w_mag_a;
        r_lo    <= func[2] ? w_mag_a : w_mag_b;
      end else begin
        r_out <= w_base;
      end
    end else if (r_state == S_CALC) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (r_div) begin
        r_acc <= w_rem;
        r_lo  <= w_quo;
      end else begin
        r_acc <= w_prod[2*WIDTH-1:WIDTH];
        r_lo  <= w_prod[WIDTH-1:0];
      end
      if (w_last) r_out <= w_calc_res;
    end
  end

endmodule

// File: tb/tb_alu_mseq.sv
// Self-checking bench for alu_mseq: directed corner cases, randomized ops
// against a 64-bit arithmetic reference, back-pressure and reset abort.
module tb_alu_mseq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_in_A;
  logic [W-1:0] alu_in_B;
  logic [2:0]   func;
  logic         control;
  logic         m_ext;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  alu_mseq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_in_A (alu_in_A),
    .alu_in_B (alu_in_B),
    .func     (func),
    .control  (control),
    .m_ext    (m_ext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic c, input logic m,
                                        input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic signed [31:0] t;
    logic [4:0]      sh;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sh  = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    if (!m) begin
      case (f)
        3'd0: r = c ? a : a + b;
        3'd1: r = a << sh;
        3'd2: r = {31'b0, (sa < sb)};
        3'd3: r = {31'b0, (ua < ub)};
        3'd4: r = a ^ b;
        3'd5: begin t = $signed(a) >>> sh; r = c ? t : a >> sh; end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else begin
      case (f)
        3'd0: begin p = sa * sb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
        3'd3: begin p = ua * ub; r = p[63:32]; end
        3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request and waits (bounded) for out_valid; leaves out_ready untouched.
  task automatic run_op(input logic [2:0] f, input logic c, input logic m,
                        input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output int lat, output bit busy_ok, output bit tmo);
    int n;
    tmo = 1'b0; busy_ok = 1'b1; lat = 0; n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin tmo = 1'b1; return; end
    in_valid = 1'b1; func = f; control = c; m_ext = m; alu_in_A = a; alu_in_B = b;
    @(posedge clk); #1;
    in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!out_valid && lat < 100) begin
      if (m && !busy) busy_ok = 1'b0;
      if (noise) begin
        alu_in_A = $urandom; alu_in_B = $urandom; func = 3'($urandom_range(0, 7));
        control = 1'($urandom_range(0, 1)); m_ext = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) tmo = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    func = 3'd0; control = 1'b0; m_ext = 1'b1; alu_in_A = 32'd3; alu_in_B = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (alu_out !== 32'h0) begin failures++; $display("FAIL reset_alu_out got=%h exp=0", alu_out); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic        c;
    logic        m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  task automatic test_directed();
    vec_t v[14];
    int lat; bit bok, tmo;
    v[0]  = '{3'd0, 1'b0, 1'b0, 32'd5,         32'd7,         32'd12};
    v[1]  = '{3'd0, 1'b1, 1'b0, 32'h1234,      32'd5,         32'h1234};
    v[2]  = '{3'd1, 1'b0, 1'b0, 32'd1,         32'h21,        32'd2};
    v[3]  = '{3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4,         32'hF800_0000};
    v[4]  = '{3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
    v[5]  = '{3'd1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[6]  = '{3'd0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0};
    v[7]  = '{3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,         32'd1};
    v[8]  = '{3'd4, 1'b0, 1'b1, 32'd7,         32'd0,         32'hFFFF_FFFF};
    v[9]  = '{3'd7, 1'b0, 1'b1, 32'd7,         32'd0,         32'd7};
    v[10] = '{3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[11] = '{3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    v[12] = '{3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[13] = '{3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].f, v[i].c, v[i].m, v[i].a, v[i].b, 1'b0, lat, bok, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL dir%0d_timeout got=timeout exp=out_valid", i); end
      checks++; if (alu_out !== v[i].e) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, alu_out, v[i].e); end
      checks++; if (lat != (v[i].m ? 32 : 0)) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].m ? 32 : 0); end
      checks++; if (!bok) begin failures++; $display("FAIL dir%0d_busy got=low exp=high_in_calc", i); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_pulse got=%0b exp=0", i, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic        c, m;
    logic [31:0] a, b, e;
    int lat, hold; bit bok, tmo;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7)); c = 1'($urandom_range(0, 1)); m = 1'($urandom_range(0, 1));
      a = pick_operand(); b = pick_operand();
      e = model(f, c, m, a, b);
      out_ready = 1'b0;
      run_op(f, c, m, a, b, 1'b1, lat, bok, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL rnd%0d_timeout got=timeout exp=out_valid", i); end
      checks++; if (alu_out !== e) begin failures++; $display("FAIL rnd%0d_result f=%0d c=%0b m=%0b a=%h b=%h got=%h exp=%h", i, f, c, m, a, b, alu_out, e); end
      checks++; if (lat != (m ? 32 : 0)) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, m ? 32 : 0); end
      checks++; if (!bok) begin failures++; $display("FAIL rnd%0d_busy got=low exp=high_in_calc", i); end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || alu_out !== e) begin failures++; $display("FAIL rnd%0d_hold valid=%0b out=%h exp_out=%h", i, out_valid, alu_out, e); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_handshake got=%0b exp=0", i, out_valid); end
      checks++; if (alu_out !== e) begin failures++; $display("FAIL rnd%0d_keep got=%h exp=%h", i, alu_out, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    int lat; bit bok, tmo;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = model(3'd4, 1'b0, 1'b0, a1, b1);
    e2 = model(3'd0, 1'b0, 1'b0, a2, b2);
    out_ready = 1'b0;
    run_op(3'd4, 1'b0, 1'b0, a1, b1, 1'b0, lat, bok, tmo);
    checks++; if (tmo || alu_out !== e1) begin failures++; $display("FAIL bp_first got=%h exp=%h tmo=%0b", alu_out, e1, tmo); end
    in_valid = 1'b1; func = 3'd0; control = 1'b0; m_ext = 1'b0; alu_in_A = a2; alu_in_B = b2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || alu_out !== e1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_stall%0d valid=%0b out=%h ready=%0b exp=1/%h/0", k, out_valid, alu_out, in_ready, e1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== e1) begin
      failures++; $display("FAIL bp_handshake valid=%0b ready=%0b out=%h exp=0/1/%h", out_valid, in_ready, alu_out, e1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || alu_out !== e2) begin
      failures++; $display("FAIL bp_next valid=%0b out=%h exp=1/%h", out_valid, alu_out, e2);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_next_pulse got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] a, b, e;
    int lat; bit bok, tmo, seen;
    out_ready = 1'b1;
    in_valid = 1'b1; func = 3'd0; control = 1'b0; m_ext = 1'b1;
    alu_in_A = $urandom | 32'h1; alu_in_B = $urandom | 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%0b exp=1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || alu_out !== 32'h0) begin
      failures++; $display("FAIL abort_calc valid=%0b busy=%0b out=%h exp=0/0/0", out_valid, busy, alu_out);
    end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%0b exp=1", in_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL abort_no_result got=pulse exp=none"); end
    a = $urandom; b = $urandom; e = model(3'd0, 1'b0, 1'b0, a, b);
    run_op(3'd0, 1'b0, 1'b0, a, b, 1'b0, lat, bok, tmo);
    checks++; if (tmo || alu_out !== e || lat != 0) begin
      failures++; $display("FAIL abort_fresh_add got=%h lat=%0d exp=%h lat=0 tmo=%0b", alu_out, lat, e, tmo);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = $urandom; b = $urandom;
    run_op(3'd6, 1'b0, 1'b0, a, b, 1'b0, lat, bok, tmo);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || alu_out !== 32'h0) begin
      failures++; $display("FAIL abort_done valid=%0b out=%h exp=0/0", out_valid, alu_out);
    end
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_done_ready got=%0b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
